tx_data_controller: RTL and testbench
=====================================

TX_DATA_CONTROLLER -- requirements
Module: tx_data_controller

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, sample-FIFO depth in I/Q words; power of two, 4..256.
REQ-002 SHALL have parameter SAMPLE_W, default 16, width of each I and Q sample.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port usb_data, input, 8, host byte from the sync-245 FIFO bus.
REQ-006 SHALL have port usb_rxf_n, input, 1, low = host byte available.
REQ-007 SHALL have port usb_oe_n, output, 1, low = bus driven by host.
REQ-008 SHALL have port usb_rd_n, output, 1, low = byte consumed this cycle.
REQ-009 SHALL have port sample_en, input, 1, one-cycle DAC sample tick.
REQ-010 SHALL have ports dac_i and dac_q, output, SAMPLE_W each, sample to the DAC.
REQ-011 SHALL have port dac_valid, output, 1, one-cycle pulse with each new sample.
REQ-012 SHALL have port underrun, output, 1, sticky flag for a tick seen with the FIFO empty.
REQ-013 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Function
REQ-014 SHALL run the host-read FSM IDLE -> OE -> READ -> IDLE.
REQ-015 IDLE SHALL go to OE when usb_rxf_n=0 and free words >= 2.
REQ-016 OE SHALL drive usb_oe_n=0 and usb_rd_n=1 for exactly one cycle, then go to READ.
REQ-017 READ SHALL drive usb_oe_n=0 and usb_rd_n=0, capturing usb_data every cycle that usb_rxf_n=0.
REQ-018 READ SHALL return to IDLE the cycle after usb_rxf_n=1, or when free words <= 1 with a word in assembly; usb_oe_n/usb_rd_n SHALL be 1 in IDLE.
REQ-019 SHALL assemble bytes little-endian in the order I[7:0], I[15:8], Q[7:0], Q[15:8]; the 2-bit byte index SHALL wrap 3 -> 0.
REQ-020 SHALL push one {I,Q} word into the FIFO the cycle after the 4th byte is captured.
REQ-021 SHALL preserve a partial word (index 1..3) across IDLE; the next burst SHALL continue it.
REQ-022 SHALL never push into a full FIFO; REQ-018 guarantees this, and the bench SHALL check it with an assertion.
REQ-023 on sample_en with the FIFO non-empty: SHALL pop, update dac_i/dac_q and pulse dac_valid one cycle later (latency 1).
REQ-024 on sample_en with the FIFO empty: SHALL hold dac_i/dac_q, leave dac_valid=0 and set underrun=1.
REQ-025 underrun SHALL clear only on rst.
REQ-026 a push and pop in the same cycle SHALL leave fifo_level unchanged; FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-027 rst SHALL force the FSM to IDLE, the byte index to 0 and the FIFO to empty.
REQ-028 rst SHALL force usb_oe_n=1, usb_rd_n=1, dac_i=0, dac_q=0, dac_valid=0, underrun=0 and fifo_level=0.
REQ-029 rst asserted mid-burst SHALL discard the partial word and release the bus on the next cycle.

Configuration
REQ-030 with macro TXDC_UNDERRUN_CNT_EN defined, SHALL add output underrun_count (16 bits) counting empty-FIFO ticks, saturating at 16'hFFFF and cleared by rst.
REQ-031 without TXDC_UNDERRUN_CNT_EN, the port and the counter SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-032 package tx_data_pkg SHALL hold the FSM state enum, the byte-order index constants and the SAMPLE_W default.
REQ-033 the FIFO SHALL be the sub-module sync_fifo (parameterised width and depth, level output); the FSM and assembler stay in the top.

Verification
REQ-034 stream bytes 34 12 78 56 with rxf_n low, then tick -> dac_i=16'h1234, dac_q=16'h5678, dac_valid high for 1 cycle.
REQ-035 rxf_n goes high after 2 bytes, then low with 2 more bytes -> exactly one word pushed, values correct, OE cycle precedes each burst.
REQ-036 host streams 80 bytes, no ticks, FIFO_DEPTH=16 -> FIFO fills to 16, rd_n high, no overflow; 16 ticks drain words in order.
REQ-037 tick with FIFO empty after a sample of 16'h0ABC -> dac_i holds 16'h0ABC, dac_valid=0, underrun=1; with TXDC_UNDERRUN_CNT_EN, 3 such ticks -> underrun_count=3.
REQ-038 rst asserted after byte 3 of a word -> next cycle oe_n=rd_n=1, level=0; a fresh 4-byte word decodes correctly.

Source files
------------

// File: rtl/tx_data_pkg.sv
// Shared types and constants for the TX data controller: host-read FSM states,
// I/Q byte order within an assembled word, and the default sample width.
package tx_data_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OE   = 2'd1,
        ST_READ = 2'd2
    } rd_state_t;

    // Position of each host byte inside the 32-bit {Q,I} word (little-endian samples)
    localparam logic [1:0] BYTE_I_LO = 2'd0;
    localparam logic [1:0] BYTE_I_HI = 2'd1;
    localparam logic [1:0] BYTE_Q_LO = 2'd2;
    localparam logic [1:0] BYTE_Q_HI = 2'd3;

    localparam int SAMPLE_W_DEF = 16;
    localparam int WORD_W       = 32;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy output; DEPTH must be a power of two so the
// pointers wrap naturally. Storage is not reset, only the pointers and level.
module sync_fifo #(
    parameter int  DATA_W = 32,
    parameter int  DEPTH  = 16,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [AW:0]       level,
    output logic              empty
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign empty   = (level == '0);

endmodule

// File: rtl/tx_data_controller.sv
// Reads I/Q bytes from a sync-245 host FIFO bus, assembles {Q,I} words, buffers them and
// feeds the DAC on each sample tick. Define TXDC_UNDERRUN_CNT_EN to add underrun_count.
module tx_data_controller
    import tx_data_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int SAMPLE_W   = SAMPLE_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  usb_data,
    input  logic                        usb_rxf_n,
    output logic                        usb_oe_n,
    output logic                        usb_rd_n,
    input  logic                        sample_en,
    output logic signed [SAMPLE_W-1:0]  dac_i,
    output logic signed [SAMPLE_W-1:0]  dac_q,
    output logic                        dac_valid,
    output logic                        underrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
`ifdef TXDC_UNDERRUN_CNT_EN
    ,
    output logic [15:0]                 underrun_count
`endif
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    function automatic logic signed [SAMPLE_W-1:0] to_sample(input logic [15:0] raw);
        return SAMPLE_W'($signed(raw));
    endfunction

    rd_state_t         state;
    logic [1:0]        byte_idx;
    logic [23:0]       asm_p0;
    logic [WORD_W-1:0] word_p1;
    logic              vld_p1;
    logic              capture;
    logic              last_byte;
    logic              pop;
    logic              fifo_empty;
    logic [WORD_W-1:0] fifo_word;
    logic [LW-1:0]     claimed;
    logic [LW-1:0]     claimed_next;

    // Slots already spoken for: stored words plus the word being pushed this cycle;
    // claimed_next also counts a word completed by this cycle's byte.
    assign capture      = (state == ST_READ) && !usb_rxf_n;
    assign last_byte    = capture && (byte_idx == BYTE_Q_HI);
    assign claimed      = fifo_level + LW'(vld_p1);
    assign claimed_next = claimed + LW'(last_byte);
    assign pop          = sample_en && !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            usb_oe_n <= 1'b1;
            usb_rd_n <= 1'b1;
            byte_idx <= BYTE_I_LO;
            vld_p1   <= 1'b0;
        end else begin
            vld_p1 <= last_byte;
            if (capture) byte_idx <= byte_idx + 2'd1;
            case (state)
                ST_IDLE: begin
                    if (!usb_rxf_n && claimed <= LW'(FIFO_DEPTH - 2)) begin
                        state    <= ST_OE;
                        usb_oe_n <= 1'b0;
                    end
                end
                ST_OE: begin
                    state    <= ST_READ;
                    usb_rd_n <= 1'b0;
                end
                ST_READ: begin
                    if (usb_rxf_n || claimed_next == LW'(FIFO_DEPTH)) begin
                        state    <= ST_IDLE;
                        usb_oe_n <= 1'b1;
                        usb_rd_n <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    usb_oe_n <= 1'b1;
                    usb_rd_n <= 1'b1;
                end
            endcase
        end
    end

    // Stage p0 -> p1: byte assembly; the 4th byte completes the word for the FIFO push
    always_ff @(posedge clk) begin
        if (capture) begin
            case (byte_idx)
                BYTE_I_LO: asm_p0[7:0]   <= usb_data;
                BYTE_I_HI: asm_p0[15:8]  <= usb_data;
                BYTE_Q_LO: asm_p0[23:16] <= usb_data;
                default:   word_p1       <= {usb_data, asm_p0};
            endcase
        end
    end

    sync_fifo #(
        .DATA_W (WORD_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (vld_p1),
        .wr_data (word_p1),
        .rd_en   (pop),
        .rd_data (fifo_word),
        .level   (fifo_level),
        .empty   (fifo_empty)
    );

    // FIFO -> DAC: one-cycle latency from the tick
    always_ff @(posedge clk) begin
        if (rst) begin
            dac_i     <= '0;
            dac_q     <= '0;
            dac_valid <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            dac_valid <= pop;
            if (pop) begin
                dac_i <= to_sample(fifo_word[15:0]);
                dac_q <= to_sample(fifo_word[31:16]);
            end
            if (sample_en && fifo_empty) underrun <= 1'b1;
        end
    end

`ifdef TXDC_UNDERRUN_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            underrun_count <= '0;
        end else if (sample_en && fifo_empty && underrun_count != 16'hFFFF) begin
            underrun_count <= underrun_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tx_data_controller.sv
// Bench for tx_data_controller: host byte queue plus a timestamped word-queue model
// of what the DAC should see; directed cases followed by a randomized run.
module tb_tx_data_controller;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  usb_data;
    logic        usb_rxf_n;
    logic        usb_oe_n;
    logic        usb_rd_n;
    logic        sample_en;
    logic [15:0] dac_i;
    logic [15:0] dac_q;
    logic        dac_valid;
    logic        underrun;
    logic [4:0]  fifo_level;
`ifdef TXDC_UNDERRUN_CNT_EN
    logic [15:0] underrun_count;
`endif

    always #5 clk = ~clk;

    tx_data_controller #(.FIFO_DEPTH(DEPTH), .SAMPLE_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .usb_data   (usb_data),
        .usb_rxf_n  (usb_rxf_n),
        .usb_oe_n   (usb_oe_n),
        .usb_rd_n   (usb_rd_n),
        .sample_en  (sample_en),
        .dac_i      (dac_i),
        .dac_q      (dac_q),
        .dac_valid  (dac_valid),
        .underrun   (underrun),
        .fifo_level (fifo_level)
`ifdef TXDC_UNDERRUN_CNT_EN
        ,
        .underrun_count (underrun_count)
`endif
    );

    typedef struct {
        logic [31:0] w;
        int          push_e;
    } mword_t;

    logic [7:0]  byte_q[$];
    logic [7:0]  asm_b[$];
    mword_t      mq[$];
    logic [31:0] fill_w [20];
    int          cyc;
    int          total;
    int          bad;
    logic [15:0] exp_i;
    logic [15:0] exp_q;
    bit          exp_valid;
    bit          exp_under;
    int          exp_cnt;
    bit          host_hold;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h cyc=%0d", tag, got, want, cyc);
        end
    endtask

    task automatic drive_host();
        usb_rxf_n = (byte_q.size() == 0) || host_hold;
        usb_data  = (byte_q.size() != 0) ? byte_q[0] : 8'h00;
    endtask

    function automatic int model_level();
        int n = 0;
        foreach (mq[k]) if (mq[k].push_e <= cyc) n++;
        return n;
    endfunction

    // One clock: model what the edge should do, then check every observable output.
    task automatic step(input bit tk);
        bit took, in_rst, pre_oe, pre_rd, pre_rxf;
        int claimed;
        logic [7:0] b;
        sample_en = tk;
        took    = !usb_rd_n && !usb_rxf_n;
        in_rst  = rst;
        pre_oe  = usb_oe_n;
        pre_rd  = usb_rd_n;
        pre_rxf = usb_rxf_n;
        claimed = mq.size();
        @(posedge clk);
        cyc++;
        #1;
        if (in_rst) begin
            asm_b.delete();
            mq.delete();
            exp_i = '0; exp_q = '0; exp_valid = 0; exp_under = 0; exp_cnt = 0;
            if (took) void'(byte_q.pop_front());
        end else begin
            exp_valid = 0;
            if (tk) begin
                if (mq.size() > 0 && mq[0].push_e < cyc) begin
                    exp_i = mq[0].w[15:0];
                    exp_q = mq[0].w[31:16];
                    exp_valid = 1;
                    void'(mq.pop_front());
                end else begin
                    exp_under = 1;
                    if (exp_cnt < 65535) exp_cnt++;
                end
            end
            if (took) begin
                b = byte_q.pop_front();
                asm_b.push_back(b);
                if (asm_b.size() == 4) begin
                    mq.push_back('{w: {asm_b[3], asm_b[2], asm_b[1], asm_b[0]}, push_e: cyc + 1});
                    asm_b.delete();
                end
            end
        end
        sample_en = 0;
        drive_host();

        check_val("level", fifo_level, model_level());
        check_val("no_overflow", fifo_level <= DEPTH, 1);
        check_val("dac_valid", dac_valid, exp_valid);
        check_val("dac_i", dac_i, exp_i);
        check_val("dac_q", dac_q, exp_q);
        check_val("underrun", underrun, exp_under);
`ifdef TXDC_UNDERRUN_CNT_EN
        check_val("underrun_count", underrun_count, exp_cnt);
`endif
        if (in_rst) begin
            check_val("rst_oe_n", usb_oe_n, 1);
            check_val("rst_rd_n", usb_rd_n, 1);
        end else begin
            if (pre_oe) check_val("idle_exit", usb_oe_n, !(!pre_rxf && claimed <= DEPTH - 2));
            if (!pre_oe && pre_rd) check_val("oe_one_cycle", usb_rd_n, 0);
            if (pre_rd && !usb_rd_n) check_val("oe_before_rd", pre_oe, 0);
            if (!pre_rd && pre_rxf) check_val("rd_release", usb_rd_n, 1);
            if (!usb_rd_n) check_val("rd_with_oe", usb_oe_n, 0);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step(0);
    endtask

    task automatic push4(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
        byte_q.push_back(b0);
        byte_q.push_back(b1);
        byte_q.push_back(b2);
        byte_q.push_back(b3);
        drive_host();
    endtask

    initial begin
        logic [7:0] rb;
        rst = 1; sample_en = 0; host_hold = 0;
        cyc = 0; total = 0; bad = 0;
        exp_i = '0; exp_q = '0; exp_valid = 0; exp_under = 0; exp_cnt = 0;
        drive_host();
        run(3);
        rst = 0;

        // Basic word decode and one-cycle dac_valid pulse
        push4(8'h34, 8'h12, 8'h78, 8'h56);
        run(12);
        check_val("a_level", fifo_level, 1);
        step(1);
        check_val("a_dac_i", dac_i, 16'h1234);
        check_val("a_dac_q", dac_q, 16'h5678);
        check_val("a_valid", dac_valid, 1);
        step(0);
        check_val("a_valid_pulse", dac_valid, 0);

        // Word split across two bursts
        byte_q.push_back(8'h11);
        byte_q.push_back(8'h22);
        drive_host();
        run(10);
        check_val("b_level0", fifo_level, 0);
        byte_q.push_back(8'h33);
        byte_q.push_back(8'h44);
        drive_host();
        run(10);
        check_val("b_level1", fifo_level, 1);
        step(1);
        check_val("b_dac_i", dac_i, 16'h2211);
        check_val("b_dac_q", dac_q, 16'h4433);

        // Underrun: output holds, flag is sticky
        push4(8'hBC, 8'h0A, 8'hEF, 8'hBE);
        run(12);
        step(1);
        check_val("c_dac_i", dac_i, 16'h0ABC);
        for (int k = 0; k < 3; k++) begin
            step(1);
            check_val("c_hold_i", dac_i, 16'h0ABC);
            check_val("c_valid", dac_valid, 0);
            check_val("c_underrun", underrun, 1);
        end
`ifdef TXDC_UNDERRUN_CNT_EN
        check_val("c_count", underrun_count, 3);
`endif
        run(5);
        check_val("c_sticky", underrun, 1);

        // Reset mid-burst after the third byte of a word
        rst = 1; step(0); rst = 0;
        check_val("d_under_clr", underrun, 0);
        push4(8'h01, 8'h02, 8'h03, 8'h04);
        for (int k = 0; k < 20 && byte_q.size() > 1; k++) step(0);
        check_val("d_three_bytes", byte_q.size(), 1);
        rst = 1; step(0); rst = 0;
        check_val("d_oe_n", usb_oe_n, 1);
        check_val("d_rd_n", usb_rd_n, 1);
        check_val("d_level", fifo_level, 0);
        push4(8'hA5, 8'h5A, 8'hC3, 8'h3C);
        run(12);
        step(1);
        check_val("d_dac_i", dac_i, 16'h5AA5);
        check_val("d_dac_q", dac_q, 16'h3CC3);

        // Fill to full with no ticks, then drain in order
        for (int k = 0; k < 80; k++) begin
            rb = 8'($urandom);
            byte_q.push_back(rb);
            fill_w[k / 4][8 * (k % 4) +: 8] = rb;
        end
        drive_host();
        run(200);
        check_val("e_full", fifo_level, 16);
        check_val("e_rd_idle", usb_rd_n, 1);
        for (int k = 0; k < 16; k++) begin
            step(1);
            check_val("e_order_i", dac_i, fill_w[k][15:0]);
            check_val("e_order_q", dac_q, fill_w[k][31:16]);
        end
        run(100);
        for (int k = 0; k < 4; k++) begin
            step(1);
            check_val("e_tail_i", dac_i, fill_w[16 + k][15:0]);
        end
        check_val("e_empty", fifo_level, 0);

        // Randomized traffic: slow ticks first (FIFO fills), fast ticks later (underruns)
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int n = 0; n < int'($urandom_range(1, 8)); n++) byte_q.push_back(8'($urandom));
            end
            host_hold = ($urandom_range(0, 4) == 0);
            drive_host();
            step($urandom_range(0, (c < 1500) ? 9 : 1) == 0);
        end
        host_hold = 0;
        drive_host();
        run(60);
        for (int k = 0; k < 40; k++) step(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
